alu_dec_seq: RTL and testbench
==============================

ALU_DEC_SEQ -- requirements
Module: alu_dec_seq

Interface
REQ-001 Parameter CTRL_W, default 4, ALU control output width; legal values >= 4.
REQ-002 Parameter MUL_LAT, default 2, cycles the multiply path is held busy; legal range 1..15.
REQ-003 Parameter DIV_LAT, default 32, cycles the divide/remainder path is held busy; legal range 1..63.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  decode request present.
REQ-007 in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
REQ-008 alu_op  input  2  00 = load/store add, 01 = branch subtract, 10 = R/I-type decode, 11 = reserved.
REQ-009 funct3  input  3  instruction funct3.
REQ-010 op5  input  1  opcode bit 5 (1 = R-type).
REQ-011 f7_5  input  1  funct7 bit 5 (instruction bit 30).
REQ-012 f7_0  input  1  funct7 bit 0 (instruction bit 25; M-extension select).
REQ-013 out_valid  output  1  decoded control available.
REQ-014 out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-015 alu_ctrl  output  CTRL_W  decoded operation, zero-extended encoding.
REQ-016 mdu_op  output  1  result is a multiply/divide op; alu_ctrl[2:0] carries funct3.
REQ-017 illegal  output  1  unsupported encoding; alu_ctrl forced to ADD.
REQ-018 busy  output  1  high while in WAIT.

Function
REQ-019 Encoding SHALL be ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
REQ-020 Decode: alu_op 00 -> ADD; 01 -> SUB; 11 -> ADD with illegal=1.
REQ-021 Decode for alu_op 10, by funct3:
  - 000: SUB iff op5 && f7_5, else ADD
  - 001: SLL; 010: SLT; 011: SLTU; 100: XOR
  - 101: SRA iff f7_5, else SRL
  - 110: OR; 111: AND
REQ-022 Inputs SHALL be decoded and registered on acceptance; outputs SHALL never be combinational from inputs.
REQ-023 FSM states SHALL be IDLE, WAIT and OUT; transitions:
  - IDLE + accept of an ALU op -> OUT
  - IDLE + accept of an MDU op -> WAIT
  - WAIT -> OUT when the counter reaches 0
  - OUT + out_ready -> IDLE, or directly to OUT/WAIT when a new request is accepted in the same cycle
REQ-024 in_ready SHALL be (state==IDLE) || (state==OUT && out_ready); it SHALL be 0 in WAIT.
REQ-025 ALU op latency SHALL be 1: out_valid rises on the edge after acceptance; back-to-back throughput is one per cycle while out_ready=1.
REQ-026 MDU ops SHALL load the counter with MUL_LAT-1 (funct3[2]=0) or DIV_LAT-1 (funct3[2]=1); out_valid SHALL rise exactly LAT+1 edges after acceptance.
REQ-027 While out_valid=1 and out_ready=0, alu_ctrl, mdu_op and illegal SHALL hold stable.
REQ-028 The counter SHALL be $clog2(max(MUL_LAT,DIV_LAT)+1) bits wide and SHALL NOT wrap below 0.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, out_valid=0, alu_ctrl=0, mdu_op=0, illegal=0, busy=0, counter=0.
REQ-030 Reset asserted in WAIT or OUT SHALL discard the pending operation; no out_valid after release.
REQ-031 in_ready SHALL be 1 on the first edge after rst_n deassertion.

Configuration
REQ-032 Macro ALU_DEC_SEQ_MEXT_EN defined: alu_op=10 && op5 && f7_0 && !f7_5 SHALL decode as MDU op (mdu_op=1, alu_ctrl={0...,funct3}) via WAIT.
REQ-033 Macro undefined: that encoding SHALL yield ADD with illegal=1, 1-cycle latency; WAIT is unreachable; busy is tied to 0.

Structure
REQ-034 Shared package alu_pkg SHALL hold the ALU encoding constants, the alu_op constants and the FSM state typedef.
REQ-035 The combinational decode SHALL be a sub-module alu_dec_core; alu_dec_seq holds the FSM, counter and output registers.

Verification
REQ-036 Reset mid-WAIT: accept DIV, assert rst_n=0 at cycle 5 -> all outputs 0, in_ready=1 after release, no stale out_valid.
REQ-037 Full decode sweep: alu_op=10, all 8 funct3 x {op5,f7_5} with out_ready=1 -> the REQ-021 value each cycle, back-to-back, one per cycle.
REQ-038 Backpressure: ADD accepted, out_ready=0 for 3 cycles -> out_valid=1 and alu_ctrl=0 stable, in_ready=0; out_ready=1 with new SUB -> next cycle alu_ctrl=1.
REQ-039 With MEXT_EN, DIV_LAT=32: DIV (funct3=100, f7_0=1) accepted at cycle 0 -> busy cycles 1..32, out_valid at cycle 33, mdu_op=1, alu_ctrl=4.
REQ-040 Without MEXT_EN: same MUL encoding -> out_valid at cycle 1, alu_ctrl=0, illegal=1, busy never 1.
REQ-041 alu_op=11 -> alu_ctrl=0, illegal=1; SRA (funct3=101, f7_5=1) -> alu_ctrl=7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder: ALU operation encoding,
// alu_op request classes and the sequencer FSM state type.
package alu_pkg;

  // ALU operation encoding; wider control buses carry these zero-extended.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // alu_op request classes coming from the main decoder.
  localparam logic [1:0] ALUOP_LS  = 2'b00;  // load/store address add
  localparam logic [1:0] ALUOP_BR  = 2'b01;  // branch compare subtract
  localparam logic [1:0] ALUOP_RI  = 2'b10;  // R/I-type, decode funct fields
  localparam logic [1:0] ALUOP_RSV = 2'b11;  // reserved, flagged illegal

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Larger of two integers, used to size the latency counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_dec_seq_if.sv
// Request/response bundle between an instruction decoder (master) and the
// ALU control sequencer (slave). Request side is a valid/ready handshake,
// result side is a valid/ready handshake plus decoded control fields.
interface alu_dec_seq_if #(
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        alu_op;
  logic [2:0]        funct3;
  logic              op5;
  logic              f7_5;
  logic              f7_0;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              mdu_op;
  logic              illegal;
  logic              busy;

  modport master (
    output in_valid, alu_op, funct3, op5, f7_5, f7_0, out_ready,
    input  in_ready, out_valid, alu_ctrl, mdu_op, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, funct3, op5, f7_5, f7_0, out_ready,
    output in_ready, out_valid, alu_ctrl, mdu_op, illegal, busy
  );
endinterface

// File: rtl/alu_dec_core.sv
// Purely combinational ALU control decode. Classifies the request as an
// ALU op, an M-extension (multiply/divide) op, or an illegal encoding.
// Optional feature: ALU_DEC_SEQ_MEXT_EN enables M-extension decode; when
// undefined the M-extension encoding is reported as illegal ADD.
import alu_pkg::*;

module alu_dec_core #(
  parameter int CTRL_W = 4
) (
  input  logic [1:0]        alu_op_i,
  input  logic [2:0]        funct3_i,
  input  logic              op5_i,
  input  logic              f7_5_i,
  input  logic              f7_0_i,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic              mdu_op_o,
  output logic              is_div_o,
  output logic              illegal_o
);

  logic [3:0] ctrl4;
  logic       mext_enc;

  // R-type with funct7 = 0000001 selects the multiply/divide unit.
  assign mext_enc = op5_i && f7_0_i && !f7_5_i;

  // funct3[2] separates the divide/remainder group from the multiply group.
  assign is_div_o = funct3_i[2];

  // Decode the request into an ALU operation and classification flags.
  always_comb begin
    ctrl4     = ALU_ADD;
    mdu_op_o  = 1'b0;
    illegal_o = 1'b0;
    case (alu_op_i)
      ALUOP_LS:  ctrl4 = ALU_ADD;
      ALUOP_BR:  ctrl4 = ALU_SUB;
      ALUOP_RSV: begin
        ctrl4     = ALU_ADD;
        illegal_o = 1'b1;
      end
      ALUOP_RI: begin
        if (mext_enc) begin
`ifdef ALU_DEC_SEQ_MEXT_EN
          mdu_op_o = 1'b1;
          ctrl4    = {1'b0, funct3_i};
`else
          ctrl4     = ALU_ADD;
          illegal_o = 1'b1;
`endif
        end else begin
          case (funct3_i)
            3'b000:  ctrl4 = (op5_i && f7_5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  ctrl4 = ALU_SLL;
            3'b010:  ctrl4 = ALU_SLT;
            3'b011:  ctrl4 = ALU_SLTU;
            3'b100:  ctrl4 = ALU_XOR;
            3'b101:  ctrl4 = f7_5_i ? ALU_SRA : ALU_SRL;
            3'b110:  ctrl4 = ALU_OR;
            default: ctrl4 = ALU_AND;
          endcase
        end
      end
      default: begin
        ctrl4     = ALU_ADD;
        illegal_o = 1'b1;
      end
    endcase
  end

  assign alu_ctrl_o = CTRL_W'(ctrl4);

endmodule

// File: rtl/alu_dec_seq.sv
// ALU control sequencer: accepts decode requests over a valid/ready
// handshake, registers the decoded control, and presents it on a result
// handshake. ALU ops complete in one cycle; multiply/divide ops hold the
// unit busy for MUL_LAT / DIV_LAT cycles before the result is offered.
// Optional feature: ALU_DEC_SEQ_MEXT_EN enables the multiply/divide path;
// without it WAIT is never entered and busy is tied low.
import alu_pkg::*;

module alu_dec_seq #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_dec_seq_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              out_valid_q;
  logic [CTRL_W-1:0] alu_ctrl_q;
  logic              mdu_op_q;
  logic              illegal_q;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_mdu;
  logic              dec_div;
  logic              dec_illegal;
  logic              in_ready;
  logic              accept;

  alu_dec_core #(
    .CTRL_W (CTRL_W)
  ) u_core (
    .alu_op_i   (bus.alu_op),
    .funct3_i   (bus.funct3),
    .op5_i      (bus.op5),
    .f7_5_i     (bus.f7_5),
    .f7_0_i     (bus.f7_0),
    .alu_ctrl_o (dec_ctrl),
    .mdu_op_o   (dec_mdu),
    .is_div_o   (dec_div),
    .illegal_o  (dec_illegal)
  );

  // A new request may enter when idle, or when the current result leaves
  // in this same cycle so back-to-back ops sustain one per cycle.
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_OUT) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Sequencer FSM with latency counter and registered result fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= '0;
      mdu_op_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_OUT: begin
          if (accept) begin
            alu_ctrl_q <= dec_ctrl;
            mdu_op_q   <= dec_mdu;
            illegal_q  <= dec_illegal;
            if (dec_mdu) begin
              state_q     <= ST_WAIT;
              cnt_q       <= dec_div ? DIV_LOAD : MUL_LOAD;
              out_valid_q <= 1'b0;
            end else begin
              state_q     <= ST_OUT;
              out_valid_q <= 1'b1;
            end
          end else if ((state_q == ST_OUT) && bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          // Counter saturates at zero; the result is offered on the edge
          // that finds it at zero.
          if (cnt_q == '0) begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.mdu_op    = mdu_op_q;
  assign bus.illegal   = illegal_q;
`ifdef ALU_DEC_SEQ_MEXT_EN
  assign bus.busy      = (state_q == ST_WAIT);
`else
  assign bus.busy      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_dec_seq.sv
// Directed testbench for alu_dec_seq. Inputs are driven and outputs are
// sampled on the falling clock edge. Expectations for the multiply/divide
// path follow ALU_DEC_SEQ_MEXT_EN.
module tb_alu_dec_seq;
  localparam int CTRL_W  = 4;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_dec_seq_if #(.CTRL_W(CTRL_W)) bus ();

  alu_dec_seq #(
    .CTRL_W  (CTRL_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                       input logic o5, input logic f75, input logic f70, input logic ordy);
    bus.in_valid  = v;
    bus.alu_op    = op;
    bus.funct3    = f3;
    bus.op5       = o5;
    bus.f7_5      = f75;
    bus.f7_0      = f70;
    bus.out_ready = ordy;
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.out_valid, bus.mdu_op, bus.illegal, bus.busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {bus.out_valid, bus.mdu_op, bus.illegal, bus.busy});
    end
    total++;
    if (bus.alu_ctrl !== 4'd0) begin
      bad++;
      $display("FAIL reset_ctrl got=%0d want=0", bus.alu_ctrl);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    $display("reset: out_valid=%b alu_ctrl=%0d in_ready=%b", bus.out_valid, bus.alu_ctrl, bus.in_ready);
    @(negedge clk);
  endtask

  task automatic test_sweep();
    // index = funct3*4 + op5*2 + f7_5
    int exp_tbl[32] = '{0, 0, 0, 1,  2, 2, 2, 2,  3, 3, 3, 3,  4, 4, 4, 4,
                        5, 5, 5, 5,  6, 7, 6, 7,  8, 8, 8, 8,  9, 9, 9, 9};
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 2'b10, i[4:2], i[1], i[0], 1'b0, 1'b1);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL sweep_in_ready i=%0d got=%b want=1", i, bus.in_ready);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 4'(exp_tbl[i]) || bus.illegal !== 1'b0 || bus.mdu_op !== 1'b0) begin
        bad++;
        $display("FAIL sweep i=%0d got valid=%b ctrl=%0d ill=%b mdu=%b want valid=1 ctrl=%0d ill=0 mdu=0",
                 i, bus.out_valid, bus.alu_ctrl, bus.illegal, bus.mdu_op, exp_tbl[i]);
      end
      $display("sweep f3=%0d op5=%0d f7_5=%0d ctrl=%0d", i[4:2], i[1], i[0], bus.alu_ctrl);
    end
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sweep_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_alu_op();
    logic [1:0] ops[4]  = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [2:0] f3s[4]  = '{3'b111, 3'b110, 3'b101, 3'b101};
    logic [3:0] ectl[4] = '{4'd0, 4'd1, 4'd0, 4'd7};
    logic       eill[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ops[i], f3s[i], 1'b0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== ectl[i] || bus.illegal !== eill[i]) begin
        bad++;
        $display("FAIL alu_op i=%0d got valid=%b ctrl=%0d ill=%b want valid=1 ctrl=%0d ill=%b",
                 i, bus.out_valid, bus.alu_ctrl, bus.illegal, ectl[i], eill[i]);
      end
      $display("alu_op op=%b f3=%b ctrl=%0d illegal=%b", ops[i], f3s[i], bus.alu_ctrl, bus.illegal);
    end
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 4'd0 || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall c=%0d got valid=%b ctrl=%0d in_ready=%b want 1/0/0",
                 c, bus.out_valid, bus.alu_ctrl, bus.in_ready);
      end
      $display("stall c=%0d valid=%b ctrl=%0d", c, bus.out_valid, bus.alu_ctrl);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_in_ready got=%b want=1", bus.in_ready);
    end
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 4'd1) begin
      bad++;
      $display("FAIL release_sub got valid=%b ctrl=%0d want 1/1", bus.out_valid, bus.alu_ctrl);
    end
    $display("release ctrl=%0d", bus.alu_ctrl);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset_in_out();
    drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.alu_ctrl !== 4'd0) begin
      bad++;
      $display("FAIL rst_out_async got valid=%b ctrl=%0d want 0/0", bus.out_valid, bus.alu_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (bus.out_valid !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
        bad++;
        $display("FAIL rst_out_stale got=1 want=0");
      end
    end
    $display("reset in OUT done");
  endtask

`ifdef ALU_DEC_SEQ_MEXT_EN
  task automatic test_mdu(input logic [2:0] f3, input int lat);
    logic err = 1'b0;
    drive(1'b1, 2'b10, f3, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 1; c <= lat; c++) begin
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) err = 1'b1;
      @(negedge clk);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL mdu_wait f3=%0d got err=1 want busy=1 valid=0 in_ready=0 for %0d cycles", f3, lat);
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.mdu_op !== 1'b1 || bus.alu_ctrl !== 4'({1'b0, f3}) || bus.busy !== 1'b0 || bus.illegal !== 1'b0) begin
      bad++;
      $display("FAIL mdu_done f3=%0d got valid=%b mdu=%b ctrl=%0d busy=%b ill=%b want 1/1/%0d/0/0",
               f3, bus.out_valid, bus.mdu_op, bus.alu_ctrl, bus.busy, bus.illegal, f3);
    end
    $display("mdu f3=%0d lat=%0d ctrl=%0d valid=%b", f3, lat, bus.alu_ctrl, bus.out_valid);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mdu_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b1, 2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.mdu_op, bus.illegal, bus.busy} !== 4'b0000 || bus.alu_ctrl !== 4'd0) begin
      bad++;
      $display("FAIL rst_wait_async got flags=%b ctrl=%0d want 0000/0",
               {bus.out_valid, bus.mdu_op, bus.illegal, bus.busy}, bus.alu_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_wait_in_ready got=%b want=1", bus.in_ready);
    end
    begin
      logic seen = 1'b0;
      for (int c = 0; c < DIV_LAT + 8; c++) begin
        @(negedge clk);
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
        bad++;
        $display("FAIL rst_wait_stale got=1 want=0");
      end
    end
    $display("reset mid-WAIT done");
  endtask
`else
  task automatic test_no_mext();
    logic [2:0] f3s[2] = '{3'b000, 3'b100};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 2'b10, f3s[i], 1'b1, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.alu_ctrl !== 4'd0 || bus.illegal !== 1'b1 || bus.mdu_op !== 1'b0 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL no_mext f3=%0d got valid=%b ctrl=%0d ill=%b mdu=%b busy=%b want 1/0/1/0/0",
                 f3s[i], bus.out_valid, bus.alu_ctrl, bus.illegal, bus.mdu_op, bus.busy);
      end
      $display("no_mext f3=%0d ctrl=%0d illegal=%b", f3s[i], bus.alu_ctrl, bus.illegal);
    end
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL no_mext_drain got valid=%b busy=%b want 0/0", bus.out_valid, bus.busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sweep();
    test_alu_op();
    test_backpressure();
    test_reset_in_out();
`ifdef ALU_DEC_SEQ_MEXT_EN
    test_mdu(3'b100, DIV_LAT);
    test_mdu(3'b000, MUL_LAT);
    test_reset_mid_wait();
`else
    test_no_mext();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
